// File: rtl/chunk_proc_pkg.sv
// Shared FSM encoding and width helper for the chunk processor slice.
package chunk_proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_FETCH    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RDY = 3'd4
    } state_e;

    // Address width for a range of n entries, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_index_counter.sv
// Sample/channel index pair walked channel-inner, pointer-outer; wraps to (0,0) after the last index.
module chunk_index_counter
    import chunk_proc_pkg::*;
#(
    parameter int IO_BUFF_SIZE = 64,
    parameter int NUM_CHANNELS = 2,
    parameter int PTR_BITS     = 6,
    parameter int CH_BITS      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                inc_i,
    output logic [PTR_BITS-1:0] ptr_o,
    output logic [CH_BITS-1:0]  ch_o,
    output logic                is_last_o
);

    logic [PTR_BITS-1:0] ptr_q, ptr_d;
    logic [CH_BITS-1:0]  ch_q, ch_d;
    logic                ch_last;

    assign ch_last   = (ch_q == CH_BITS'(NUM_CHANNELS - 1));
    assign is_last_o = ch_last && (ptr_q == PTR_BITS'(IO_BUFF_SIZE - 1));

    always_comb begin
        ptr_d = ptr_q;
        ch_d  = ch_q;
        if (clear_i || (inc_i && is_last_o)) begin
            ptr_d = '0;
            ch_d  = '0;
        end else if (inc_i) begin
            if (ch_last) begin
                ch_d  = '0;
                ptr_d = ptr_q + PTR_BITS'(1);
            end else begin
                ch_d = ch_q + CH_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            ch_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            ch_q  <= ch_d;
        end
    end

    assign ptr_o = ptr_q;
    assign ch_o  = ch_q;

endmodule

// File: rtl/multichannel_chunk_processor.sv
// Chunk-triggered sequencer moving every (ptr, ch) sample from the input buffer to the output
// buffer, either through an external filter (rfd/nd/rdy handshake) or straight across in bypass.
module multichannel_chunk_processor
    import chunk_proc_pkg::*;
#(
    parameter  int SAMPLE_SIZE  = 24,
    parameter  int IO_BUFF_SIZE = 64,
    parameter  int NUM_CHANNELS = 2,
    parameter  int START_DELAY  = 64,
    localparam int PTR_BITS     = cnt_width(IO_BUFF_SIZE),
    localparam int CH_BITS      = cnt_width(NUM_CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   chunk_pulse,
    input  logic                   bypass,
    output logic [PTR_BITS-1:0]    in_ptr,
    output logic [CH_BITS-1:0]     in_ch,
    input  logic [SAMPLE_SIZE-1:0] in_sample,
    output logic [PTR_BITS-1:0]    out_ptr,
    output logic [CH_BITS-1:0]     out_ch,
    output logic [SAMPLE_SIZE-1:0] out_sample,
    output logic                   out_we,
    output logic [SAMPLE_SIZE-1:0] filt_din,
    output logic                   filt_nd,
    input  logic                   filt_rfd,
    input  logic                   filt_rdy,
    input  logic [SAMPLE_SIZE-1:0] filt_dout,
    output logic                   busy,
    output logic                   chunk_done,
    output logic                   overrun
);

    localparam int DLY_BITS = cnt_width(START_DELAY + 1);

    state_e              state_q, state_d;
    logic [DLY_BITS-1:0] dly_q, dly_d;
    logic                bypass_q, bypass_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                advance;
    logic                is_last;
    logic [PTR_BITS-1:0] ptr;
    logic [CH_BITS-1:0]  ch;

    chunk_index_counter #(
        .IO_BUFF_SIZE(IO_BUFF_SIZE),
        .NUM_CHANNELS(NUM_CHANNELS),
        .PTR_BITS    (PTR_BITS),
        .CH_BITS     (CH_BITS)
    ) u_index (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == ST_IDLE),
        .inc_i    (advance),
        .ptr_o    (ptr),
        .ch_o     (ch),
        .is_last_o(is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            bypass_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            bypass_q  <= bypass_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        bypass_d = bypass_q;
        advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chunk_pulse) begin
                    bypass_d = bypass;
                    state_d  = (START_DELAY == 0) ? ST_FETCH : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dly_q == DLY_BITS'(START_DELAY - 1)) begin
                    dly_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    dly_d = dly_q + DLY_BITS'(1);
                end
            end
            ST_FETCH: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (bypass_q) begin
                    advance = 1'b1;
                end else if (filt_rfd) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: advance = filt_rdy;
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            state_d = is_last ? ST_IDLE : ST_FETCH;
        end
        done_d    = advance && is_last;
        overrun_d = chunk_pulse && (state_q != ST_IDLE);
    end

    // Write data is combinational so the output buffer captures it in the same cycle as out_we.
    always_comb begin
        out_we     = 1'b0;
        out_sample = '0;
        filt_nd    = 1'b0;
        filt_din   = '0;
        case (state_q)
            ST_ISSUE: begin
                if (bypass_q) begin
                    out_we     = 1'b1;
                    out_sample = in_sample;
                end else begin
                    filt_din = in_sample;
                    filt_nd  = filt_rfd;
                end
            end
            ST_WAIT_RDY: begin
                if (filt_rdy) begin
                    out_we     = 1'b1;
                    out_sample = filt_dout;
                end
            end
            default: ;
        endcase
    end

    assign in_ptr     = ptr;
    assign in_ch      = ch;
    assign out_ptr    = ptr;
    assign out_ch     = ch;
    assign busy       = (state_q != ST_IDLE);
    assign chunk_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_multichannel_chunk_processor.sv
// Directed bench: filter, bypass, rfd stall, overrun, mid-chunk reset and a zero-delay mono build.
module tb_multichannel_chunk_processor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chunk_pulse = 1'b0;
    logic        bypass = 1'b0;
    logic [1:0]  in_ptr, out_ptr;
    logic [0:0]  in_ch, out_ch;
    logic [23:0] in_sample = '0;
    logic [23:0] out_sample, filt_din, filt_dout;
    logic        out_we, filt_nd, busy, chunk_done, overrun;
    logic        filt_rfd = 1'b1;
    logic        filt_rdy;
    logic        spur_rdy = 1'b0;

    logic        chunk_pulse6 = 1'b0;
    logic [1:0]  in_ptr6, out_ptr6;
    logic [0:0]  in_ch6, out_ch6;
    logic [23:0] in_sample6 = '0;
    logic [23:0] out_sample6, filt_din6;
    logic        out_we6, filt_nd6, busy6, chunk_done6, overrun6;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multichannel_chunk_processor #(
        .SAMPLE_SIZE(24), .IO_BUFF_SIZE(4), .NUM_CHANNELS(2), .START_DELAY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .chunk_pulse(chunk_pulse), .bypass(bypass),
        .in_ptr(in_ptr), .in_ch(in_ch), .in_sample(in_sample),
        .out_ptr(out_ptr), .out_ch(out_ch), .out_sample(out_sample), .out_we(out_we),
        .filt_din(filt_din), .filt_nd(filt_nd), .filt_rfd(filt_rfd), .filt_rdy(filt_rdy),
        .filt_dout(filt_dout), .busy(busy), .chunk_done(chunk_done), .overrun(overrun)
    );

    multichannel_chunk_processor #(
        .SAMPLE_SIZE(24), .IO_BUFF_SIZE(4), .NUM_CHANNELS(1), .START_DELAY(0)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .chunk_pulse(chunk_pulse6), .bypass(1'b1),
        .in_ptr(in_ptr6), .in_ch(in_ch6), .in_sample(in_sample6),
        .out_ptr(out_ptr6), .out_ch(out_ch6), .out_sample(out_sample6), .out_we(out_we6),
        .filt_din(filt_din6), .filt_nd(filt_nd6), .filt_rfd(1'b0), .filt_rdy(1'b0),
        .filt_dout(24'h0), .busy(busy6), .chunk_done(chunk_done6), .overrun(overrun6)
    );

    function automatic logic [23:0] mem_val(input int p, input int c);
        return 24'h100000 + 24'(c * 256) + 24'(p * 17);
    endfunction

    // input buffer RAM with one-cycle read latency
    always @(posedge clk) begin
        in_sample  <= mem_val(int'(in_ptr), int'(in_ch));
        in_sample6 <= mem_val(int'(in_ptr6), int'(in_ch6));
    end

    // filter model: dout = din + 1, rdy two cycles after nd
    logic [1:0]  pipe_v = '0;
    logic [23:0] pipe_d0 = '0, pipe_d1 = '0;
    always @(posedge clk) begin
        pipe_v  <= {pipe_v[0], filt_nd};
        pipe_d0 <= filt_din + 24'd1;
        pipe_d1 <= pipe_d0;
    end
    assign filt_rdy  = pipe_v[1] | spur_rdy;
    assign filt_dout = spur_rdy ? 24'hBADBAD : pipe_d1;

    // output-side monitors
    logic [31:0] wr_data_q[$], wr_ptr_q[$], wr_ch_q[$], wr_cyc_q[$];
    logic [31:0] w6_data_q[$], w6_ptr_q[$], w6_ch_q[$], w6_cyc_q[$];
    int nd_cnt = 0, done_cnt = 0, ov_cnt = 0, done_cyc = 0;
    int done6_cnt = 0, nd6_cnt = 0, ov6_cnt = 0;

    always @(negedge clk) begin
        if (out_we) begin
            wr_data_q.push_back(32'(out_sample));
            wr_ptr_q.push_back(32'(out_ptr));
            wr_ch_q.push_back(32'(out_ch));
            wr_cyc_q.push_back(32'(cyc));
        end
        if (filt_nd) nd_cnt++;
        if (chunk_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (overrun) ov_cnt++;
        if (out_we6) begin
            w6_data_q.push_back(32'(out_sample6));
            w6_ptr_q.push_back(32'(out_ptr6));
            w6_ch_q.push_back(32'(out_ch6));
            w6_cyc_q.push_back(32'(cyc));
        end
        if (chunk_done6) done6_cnt++;
        if (filt_nd6) nd6_cnt++;
        if (overrun6) ov6_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_data_q.delete(); wr_ptr_q.delete(); wr_ch_q.delete(); wr_cyc_q.delete();
        nd_cnt = 0; done_cnt = 0; ov_cnt = 0; done_cyc = 0;
    endtask

    task automatic pulse(output int pcyc);
        @(posedge clk); #1;
        chunk_pulse = 1'b1;
        pcyc = cyc;
        @(posedge clk); #1;
        chunk_pulse = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n);
        int k = 0;
        while (wr_data_q.size() < n && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, "_wait_writes"}, 32'(wr_data_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, "_wait_done"}, 32'(done_cnt > 0), 32'd1);
    endtask

    // scoreboard: expected (p,c) order and data for one chunk of the main instance
    task automatic verify_chunk(input string tag, input bit add_one);
        logic [31:0] exp_q[$];
        int n;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 2; c++)
                exp_q.push_back(32'(mem_val(p, c)) + (add_one ? 32'd1 : 32'd0));
        n = wr_data_q.size();
        check({tag, "_writes"}, 32'(n), 32'd8);
        for (int i = 0; i < n && i < 8; i++) begin
            check({tag, "_ptr"}, wr_ptr_q[i], 32'(i / 2));
            check({tag, "_ch"}, wr_ch_q[i], 32'(i % 2));
            check({tag, "_data"}, wr_data_q[i], exp_q.pop_front());
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (n > 0) check({tag, "_done_cycle"}, 32'(done_cyc), wr_cyc_q[n-1] + 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_we"}, 32'(out_we), 32'd0);
        check({tag, "_filt_nd"}, 32'(filt_nd), 32'd0);
        check({tag, "_in_ptr"}, 32'(in_ptr), 32'd0);
        check({tag, "_in_ch"}, 32'(in_ch), 32'd0);
        check({tag, "_out_sample"}, 32'(out_sample), 32'd0);
        check({tag, "_filt_din"}, 32'(filt_din), 32'd0);
        check({tag, "_chunk_done"}, 32'(chunk_done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int pc;
        int k;

        // reset
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_busy6", 32'(busy6), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: filter path
        clear_log();
        bypass = 1'b0;
        filt_rfd = 1'b1;
        pulse(pc);
        wait_done("filt");
        verify_chunk("filt", 1'b1);
        check("filt_nd_cnt", 32'(nd_cnt), 32'd8);
        check("filt_overrun", 32'(ov_cnt), 32'd0);

        // 2: bypass, with bypass dropped mid-chunk
        repeat (3) @(posedge clk);
        clear_log();
        bypass = 1'b1;
        pulse(pc);
        bypass = 1'b0;
        wait_done("byp");
        verify_chunk("byp", 1'b0);
        check("byp_nd_cnt", 32'(nd_cnt), 32'd0);
        if (wr_cyc_q.size() > 0) check("byp_first_latency", wr_cyc_q[0] - 32'(pc), 32'd5);
        for (int i = 1; i < wr_cyc_q.size(); i++)
            check("byp_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 32'd2);

        // 3: rfd stall plus spurious rdy outside WAIT_RDY
        repeat (3) @(posedge clk);
        clear_log();
        filt_rfd = 1'b0;
        pulse(pc);
        repeat (7) @(posedge clk);
        #1 spur_rdy = 1'b1;
        @(posedge clk); #1 spur_rdy = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stall_nd_cnt", 32'(nd_cnt), 32'd0);
        check("stall_writes", 32'(wr_data_q.size()), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        filt_rfd = 1'b1;
        wait_writes("stall", 1);
        @(posedge clk); #1 spur_rdy = 1'b1;
        @(posedge clk); #1 spur_rdy = 1'b0;
        wait_done("stall");
        verify_chunk("stall", 1'b1);
        check("stall_nd_total", 32'(nd_cnt), 32'd8);

        // 4: overrun mid-chunk, then a pulse coinciding with chunk_done
        repeat (3) @(posedge clk);
        clear_log();
        pulse(pc);
        wait_writes("ovr", 5);
        chunk_pulse = 1'b1;
        @(posedge clk); #1 chunk_pulse = 1'b0;
        wait_done("ovr");
        verify_chunk("ovr", 1'b1);
        check("ovr_overrun_cnt", 32'(ov_cnt), 32'd1);
        chunk_pulse = 1'b1;
        @(posedge clk); #1 chunk_pulse = 1'b0;
        clear_log();
        wait_done("back2back");
        verify_chunk("back2back", 1'b1);
        check("back2back_overrun", 32'(ov_cnt), 32'd0);

        // 5: asynchronous reset during WAIT_RDY of write #3
        repeat (3) @(posedge clk);
        clear_log();
        pulse(pc);
        k = 0;
        while (nd_cnt < 3 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check("rst_wait_nd", 32'(nd_cnt), 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_writes", 32'(wr_data_q.size()), 32'd2);
        check("midrst_idle", 32'(busy), 32'd0);
        clear_log();
        pulse(pc);
        wait_done("postrst");
        verify_chunk("postrst", 1'b1);

        // 6: zero start delay, single channel, bypass
        repeat (3) @(posedge clk);
        #1 chunk_pulse6 = 1'b1;
        pc = cyc;
        @(posedge clk); #1 chunk_pulse6 = 1'b0;
        check("mono_busy_fetch", 32'(busy6), 32'd1);
        k = 0;
        while (done6_cnt == 0 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("mono_done_cnt", 32'(done6_cnt), 32'd1);
        check("mono_writes", 32'(w6_data_q.size()), 32'd4);
        if (w6_cyc_q.size() > 0) check("mono_first_latency", w6_cyc_q[0] - 32'(pc), 32'd2);
        for (int i = 0; i < w6_data_q.size() && i < 4; i++) begin
            check("mono_ptr", w6_ptr_q[i], 32'(i));
            check("mono_ch", w6_ch_q[i], 32'd0);
            check("mono_data", w6_data_q[i], 32'(mem_val(i, 0)));
        end
        check("mono_nd", 32'(nd6_cnt), 32'd0);
        check("mono_overrun", 32'(ov6_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
